// File: rtl/modexp_sequencer.sv
// -----------------------------------------------------------------------------
// modexp_sequencer
//
// Left-to-right square-and-multiply controller for modular exponentiation.
// It drives one shared Montgomery multiplier core through every squaring and
// multiplication of X^E mod M. All operands stay in the Montgomery domain.
//
// Optional feature (compile-time macro): MODEXP_FINAL_CONVERT_EN
//   defined   : a final multiply by the integer one brings the accumulator out
//               of the Montgomery domain, so result = X^E mod M.
//   undefined : the conversion step is dropped and result stays in the
//               Montgomery domain (X^E * R mod M).
//
// Parameters
//   N    operand / modulus width
//   E_W  exponent register width
//   LW   width of in_e_len (holds 0..E_W; larger values are clamped to E_W)
//
// Ports
//   clk        clock
//   resetn     synchronous, active-low reset
//   start      request pulse, sampled in IDLE only
//   in_x       base in Montgomery form (X*R mod M)
//   in_one     Montgomery one (R mod M)
//   in_m       odd modulus
//   in_e       exponent
//   in_e_len   number of exponent bits to process, from bit 0 upward
//   busy       high in every state except IDLE and DONE
//   done       one-cycle pulse; result is valid in that cycle
//   result     final value, held until the next accepted start
//   mm_start   one-cycle start to the Montgomery core
//   mm_a/b/m   core operands, registered, stable from mm_start to mm_done
//   mm_result  core output, valid only while mm_done = 1
//   mm_done    core completion pulse
// -----------------------------------------------------------------------------
module modexp_sequencer #(
    parameter int N   = 1024,
    parameter int E_W = 1024,
    parameter int LW  = 11
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [N-1:0]   in_x,
    input  logic [N-1:0]   in_one,
    input  logic [N-1:0]   in_m,
    input  logic [E_W-1:0] in_e,
    input  logic [LW-1:0]  in_e_len,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result,
    output logic           mm_start,
    output logic [N-1:0]   mm_a,
    output logic [N-1:0]   mm_b,
    output logic [N-1:0]   mm_m,
    input  logic [N-1:0]   mm_result,
    input  logic           mm_done
);

    localparam int IW = (E_W > 1) ? $clog2(E_W) : 1;

    typedef enum logic [3:0] {
        IDLE,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        NEXT,
        CONV_START,
        CONV_WAIT,
        DONE
    } state_t;

    // Where the sequencer goes once the last exponent bit has been handled
    // (and directly from IDLE for a zero-length exponent).
`ifdef MODEXP_FINAL_CONVERT_EN
    localparam state_t AFTER_LAST = CONV_START;
`else
    localparam state_t AFTER_LAST = DONE;
`endif

    state_t          state_q, state_d;
    logic [N-1:0]    x_q, x_d;
    logic [N-1:0]    m_q, m_d;
    logic [E_W-1:0]  e_q, e_d;
    logic [N-1:0]    a_q, a_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    mm_a_q, mm_a_d;
    logic [N-1:0]    mm_b_q, mm_b_d;
    logic [N-1:0]    mm_m_q, mm_m_d;
    logic [N-1:0]    result_q, result_d;

    // The Montgomery one is only needed to seed the accumulator at start, so
    // it is written straight into A instead of being kept in its own register.

    // Requested length clamped to the exponent register width.
    logic [31:0] len_ext;
    logic [31:0] len_clamped;

    assign len_ext     = 32'(in_e_len);
    assign len_clamped = (len_ext > 32'(E_W)) ? 32'(E_W) : len_ext;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, regardless of the
    // order the simulator evaluates processes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            x_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            a_q      <= '0;
            idx_q    <= '0;
            mm_a_q   <= '0;
            mm_b_q   <= '0;
            mm_m_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            m_q      <= m_d;
            e_q      <= e_d;
            a_q      <= a_d;
            idx_q    <= idx_d;
            mm_a_q   <= mm_a_d;
            mm_b_q   <= mm_b_d;
            mm_m_q   <= mm_m_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a hold default first, so no
        // path through the case statements can leave one unassigned and
        // infer a latch.
        state_d  = state_q;
        x_d      = x_q;
        m_d      = m_q;
        e_d      = e_q;
        a_d      = a_q;
        idx_d    = idx_q;
        mm_a_d   = mm_a_q;
        mm_b_d   = mm_b_q;
        mm_m_d   = mm_m_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d   = in_x;
                    m_d   = in_m;
                    e_d   = in_e;
                    a_d   = in_one;
                    // Wraps to all-ones for a zero length; idx is unused then.
                    idx_d = IW'(len_clamped - 32'd1);
                    state_d = (len_clamped == 32'd0) ? AFTER_LAST : SQ_START;
                end
            end

            SQ_START: state_d = SQ_WAIT;

            SQ_WAIT: begin
                if (mm_done) begin
                    a_d     = mm_result;
                    state_d = e_q[idx_q] ? MUL_START : NEXT;
                end
            end

            MUL_START: state_d = MUL_WAIT;

            MUL_WAIT: begin
                if (mm_done) begin
                    a_d     = mm_result;
                    state_d = NEXT;
                end
            end

            NEXT: begin
                if (idx_q == '0) begin
                    state_d = AFTER_LAST;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = SQ_START;
                end
            end

`ifdef MODEXP_FINAL_CONVERT_EN
            CONV_START: state_d = CONV_WAIT;

            CONV_WAIT: begin
                if (mm_done) begin
                    a_d     = mm_result;
                    state_d = DONE;
                end
            end
`endif

            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase

        // Operands are loaded on entry to a *_START state from the values the
        // accumulator and operand registers will hold in that state, so they
        // are already valid in the mm_start cycle and frozen through the wait.
        // result is loaded on entry to DONE so it is valid alongside done.
        case (state_d)
            SQ_START: begin
                mm_a_d = a_d;
                mm_b_d = a_d;
                mm_m_d = m_d;
            end
            MUL_START: begin
                mm_a_d = a_d;
                mm_b_d = x_d;
                mm_m_d = m_d;
            end
`ifdef MODEXP_FINAL_CONVERT_EN
            CONV_START: begin
                // Multiplying by the plain integer one strips the R factor.
                mm_a_d = a_d;
                mm_b_d = N'(1);
                mm_m_d = m_d;
            end
`endif
            DONE: result_d = a_d;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from the state register or driven by registers)
    // -------------------------------------------------------------------------
    assign mm_start = (state_q == SQ_START) || (state_q == MUL_START) ||
                      (state_q == CONV_START);
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_m     = mm_m_q;

endmodule
